cpu_seq: RTL and testbench
==========================

CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 Parameter DW, 8, data width of register-file words and the ALU.
REQ-002 Parameter PCW, 8, program-counter and instruction-address width.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  single-cycle pulse; begins execution at pc=0 when idle or halted.
REQ-006 imem_req  out  1  fetch request, held high until accepted.
REQ-007 imem_addr  out  PCW  fetch address, equal to pc while imem_req is high.
REQ-008 imem_valid  in  1  fetch data valid; any latency of 1 or more cycles after imem_req.
REQ-009 imem_data  in  16  instruction word.
REQ-010 rf_arad, rf_brad  out  2  register-file read addresses.
REQ-011 rf_a, rf_b  in  DW  register-file read data, combinational from rf_arad/rf_brad.
REQ-012 rf_we  out  1, rf_wad  out  2, rf_wd  out  DW  register-file write port, sampled by the file on the rising edge.
REQ-013 pc  out  PCW  current program counter.
REQ-014 busy  out  1  high in FETCH, EXEC and WB.
REQ-015 halted  out  1  high in HALT.
REQ-016 illegal  out  1  sticky; set by an undefined opcode, cleared by start.

Function
REQ-017 Instruction fields: op[15:12], rd[11:10], ra[9:8], rb[7:6], imm[7:0]; imm is zero-extended or truncated to DW or PCW as needed.
REQ-018 Opcodes:
- 0 NOP
- 1 LDI: rd <= imm
- 2 ADD: rd <= ra+rb
- 3 SUB: rd <= ra-rb
- 4 AND
- 5 OR
- 6 MOV: rd <= ra
- 7 JZ: if ra==0 then pc <= imm
- 8 HALT
- 9-15 undefined
REQ-019 ALU results are computed modulo 2^DW; carry and borrow are discarded.
REQ-020 The FSM has states IDLE, FETCH, EXEC, WB and HALT.
- IDLE to FETCH on start.
- FETCH to EXEC on the cycle imem_valid is high; the instruction register captures imem_data.
- EXEC to WB for ops 1-6.
- EXEC to FETCH for NOP and JZ.
- EXEC to HALT for HALT or an undefined op.
- WB to FETCH.
- HALT to FETCH on start, with pc=0.
REQ-021 In EXEC, rf_arad=ra and rf_brad=rb. The ALU result is registered at the end of EXEC.
REQ-022 In WB, rf_we=1 for exactly one cycle, with rf_wad=rd and rf_wd set to the registered result.
REQ-023 rf_we is 0 in every state other than WB.
REQ-024 pc increments by 1, wrapping at 2^PCW-1 to 0, at the end of EXEC, except for a taken JZ (pc <= imm) and for HALT or an undefined op (pc holds).
REQ-025 Cycles per instruction:
- ALU/LDI/MOV: fetch latency + 2
- NOP/JZ: fetch latency + 1
REQ-026 imem_req is high only in FETCH. imem_valid is ignored outside FETCH.
REQ-027 start is ignored while busy.
REQ-028 Back-to-back dependent instructions need no forwarding, because the WB write completes before the next EXEC read.

Reset
REQ-029 On rst the following values apply:
- state=IDLE, pc=0, instruction register=0, result register=0
- imem_req=0, rf_we=0, rf_wad=0, rf_wd=0, rf_arad=0, rf_brad=0
- busy=0, halted=0, illegal=0
REQ-030 rst asserted mid-fetch or mid-WB aborts immediately; no write is issued after rst asserts.
REQ-031 A response that arrives after reset is ignored, because the FSM is in IDLE.

Structure
REQ-032 DW, PCW, the opcode enumeration, the state enumeration and the field bit positions live in the shared cpu package or header.
REQ-033 The ALU (op, a, b, imm to result) is one combinational sub-module, cpu_alu.
REQ-034 The register file remains a separate module and is not instantiated inside cpu_seq.

Verification
REQ-035 Program LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT, with 1-cycle fetch latency:
- r3=8
- halted=1
- pc=3
- rf_we high exactly 3 cycles
REQ-036 Program LDI r0,0x01; LDI r1,0x02; SUB r2,r0,r1 -> r2=0xFF, confirming wrap-around.
REQ-037 JZ loop: LDI r0,0; JZ r0,0x10 -> next imem_addr=0x10. With r0=1 the next imem_addr is pc+1.
REQ-038 Random fetch latency of 1-5 cycles:
- imem_req stays stable until imem_valid
- results match the 1-cycle run
- start pulses while busy have no effect
REQ-039 Opcode 0xB -> illegal=1, halted=1, no rf_we. A following start clears illegal and fetches from address 0.
REQ-040 rst asserted during WB and during an outstanding fetch -> all outputs at reset values in the same cycle; a later imem_valid causes no state change.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared widths, opcode/state encodings and instruction field positions
package cpu_seq_pkg;
  localparam int DW = 8;
  localparam int PCW = 8;
  localparam int OP_LSB = 12;
  localparam int RD_LSB = 10;
  localparam int RA_LSB = 8;
  localparam int RB_LSB = 6;
  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_JZ, OP_HALT
  } op_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WB, S_HALT} state_e;
  function automatic logic f_writes(input logic [3:0] op);
    return op >= OP_LDI && op <= OP_MOV;
  endfunction
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU for LDI/ADD/SUB/AND/OR/MOV, results modulo 2^DW
// Ports: i_op opcode, i_a/i_b register operands, i_imm immediate, o_res result
module cpu_alu #(
  parameter int DW = 8
) (
  input  logic [3:0]    i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [7:0]    i_imm,
  output logic [DW-1:0] o_res
);
  import cpu_seq_pkg::*;
  always_comb
    o_res = i_op == OP_LDI ? DW'(i_imm) :
            i_op == OP_ADD ? i_a + i_b :
            i_op == OP_SUB ? i_a - i_b :
            i_op == OP_AND ? i_a & i_b :
            i_op == OP_OR  ? i_a | i_b :
            i_op == OP_MOV ? i_a : '0;
endmodule

// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle sequencer fetching 16-bit instructions and driving an external register file
// Ports: clk/rst (async, active-high); start pulse; imem_req/addr/valid/data fetch handshake;
//        rf_arad/rf_brad/rf_a/rf_b read port; rf_we/rf_wad/rf_wd write port; pc, busy, halted, illegal status
module cpu_seq #(
  parameter int DW  = cpu_seq_pkg::DW,
  parameter int PCW = cpu_seq_pkg::PCW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_valid,
  input  logic [15:0]    imem_data,
  output logic [1:0]     rf_arad,
  output logic [1:0]     rf_brad,
  input  logic [DW-1:0]  rf_a,
  input  logic [DW-1:0]  rf_b,
  output logic           rf_we,
  output logic [1:0]     rf_wad,
  output logic [DW-1:0]  rf_wd,
  output logic [PCW-1:0] pc,
  output logic           busy,
  output logic           halted,
  output logic           illegal
);
  import cpu_seq_pkg::*;
  state_e         r_state, w_next;
  logic [15:0]    r_ir;
  logic [PCW-1:0] r_pc;
  logic [DW-1:0]  r_res, w_res;
  logic           r_illegal;
  logic [3:0]     w_op;
  logic [1:0]     w_rd, w_ra, w_rb;
  logic [7:0]     w_imm;
  logic           w_idle, w_wr, w_def, w_jmp;
  assign w_op   = r_ir[OP_LSB +: 4];
  assign w_rd   = r_ir[RD_LSB +: 2];
  assign w_ra   = r_ir[RA_LSB +: 2];
  assign w_rb   = r_ir[RB_LSB +: 2];
  assign w_imm  = r_ir[7:0];
  assign w_idle = r_state == S_IDLE || r_state == S_HALT;
  assign w_wr   = f_writes(w_op);
  assign w_def  = w_op <= OP_HALT;
  // rf_a is the ra operand only while in EXEC, which is the only place w_jmp is used
  assign w_jmp  = w_op == OP_JZ && rf_a == '0;
  cpu_alu #(.DW(DW)) u_alu (
    .i_op (w_op),
    .i_a  (rf_a),
    .i_b  (rf_b),
    .i_imm(w_imm),
    .o_res(w_res)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALT: if (start) w_next = S_FETCH;
      S_FETCH:        if (imem_valid) w_next = S_EXEC;
      S_EXEC:
        if (w_wr) w_next = S_WB;
        else if (w_op == OP_NOP || w_op == OP_JZ) w_next = S_FETCH;
        else w_next = S_HALT;
      S_WB:           w_next = S_FETCH;
      default:        w_next = S_IDLE;
    endcase
  end
  // write-port fields are forced to zero outside WB so reset and idle values are clean
  always_comb begin
    imem_req = r_state == S_FETCH;
    busy     = r_state == S_FETCH || r_state == S_EXEC || r_state == S_WB;
    halted   = r_state == S_HALT;
    rf_arad  = r_state == S_EXEC ? w_ra : '0;
    rf_brad  = r_state == S_EXEC ? w_rb : '0;
    rf_we    = r_state == S_WB;
    rf_wad   = rf_we ? w_rd : '0;
    rf_wd    = rf_we ? r_res : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ir      <= '0;
      r_res     <= '0;
      r_pc      <= '0;
      r_illegal <= 1'b0;
    end else if (w_idle) begin
      if (start) begin
        r_pc      <= '0;
        r_illegal <= 1'b0;
      end
    end else if (r_state == S_FETCH) begin
      if (imem_valid) r_ir <= imem_data;
    end else if (r_state == S_EXEC) begin
      r_res     <= w_res;
      r_pc      <= w_jmp ? PCW'(w_imm) : (w_def && w_op != OP_HALT) ? r_pc + PCW'(1) : r_pc;
      r_illegal <= r_illegal | ~w_def;
    end
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign illegal   = r_illegal;
endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: table-driven programs with a write scoreboard, plus reset/restart corner sequences
module tb_cpu_seq;
  localparam logic [15:0] HALT = 16'h8000;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, imem_valid = 1'b0, rf_clr = 1'b0;
  logic [15:0] imem_data = '0;
  logic        imem_req, rf_we, busy, halted, illegal;
  logic [7:0]  imem_addr, pc, rf_a, rf_b, rf_wd, pend_addr;
  logic [1:0]  rf_arad, rf_brad, rf_wad;
  logic [7:0]  rf [4];
  logic [15:0] mem [256];
  logic [9:0]  q [$];
  int          vec = 0, err = 0, we_cnt = 0, lat = 1, cnt = 0;
  bit          resp_on = 1'b1, mon_on = 1'b1, pend = 1'b0;
  typedef struct {
    logic [7:0][15:0] prog;
    int               n;
    int               lat;
    bit               poke;
    int               cyc;
    logic [7:0]       pc;
    bit               ill;
    int               nwr;
    logic [5:0][9:0]  wr;
  } vec_t;
  vec_t v [8];

  always #5 clk = ~clk;

  cpu_seq #(.DW(8), .PCW(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .rf_arad(rf_arad), .rf_brad(rf_brad), .rf_a(rf_a), .rf_b(rf_b),
    .rf_we(rf_we), .rf_wad(rf_wad), .rf_wd(rf_wd),
    .pc(pc), .busy(busy), .halted(halted), .illegal(illegal)
  );

  assign rf_a = rf[rf_arad];
  assign rf_b = rf[rf_brad];
  always @(posedge clk)
    if (rf_clr) begin
      for (int k = 0; k < 4; k++) rf[k] <= '0;
    end else if (rf_we) rf[rf_wad] <= rf_wd;

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {4'h1, rd, 2'b00, imm};
  endfunction
  function automatic logic [15:0] alu(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra, input logic [1:0] rb);
    return {op, rd, ra, rb, 6'b0};
  endfunction
  function automatic logic [15:0] jz(input logic [1:0] ra, input logic [7:0] imm);
    return {4'h7, 2'b00, ra, imm};
  endfunction
  function automatic logic [9:0] w(input logic [1:0] rd, input logic [7:0] val);
    return {rd, val};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic hdr(input int i, input int n, input int l, input bit pk, input int cy, input logic [7:0] p, input bit il, input int nw);
    v[i].n = n; v[i].lat = l; v[i].poke = pk; v[i].cyc = cy; v[i].pc = p; v[i].ill = il; v[i].nwr = nw;
  endtask

  task automatic load(input int i);
    for (int a = 0; a < 256; a++) mem[a] = HALT;
    for (int k = 0; k < v[i].n; k++) mem[k] = v[i].prog[k];
    lat = v[i].lat;
    rf_clr = 1'b1;
    @(negedge clk);
    rf_clr = 1'b0;
  endtask

  task automatic run(input bit poke, output int cyc);
    bit done;
    done = 1'b0;
    cyc = 0;
    we_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i < 600 && !done; i++) begin
      @(negedge clk);
      if (halted) begin
        done = 1'b1;
        cyc = i - 1;
      end else start = poke && busy && $urandom_range(0, 1) == 1;
    end
    start = 1'b0;
    chk("halt_timeout", 32'(done), 1);
  endtask

  // instruction memory: answers each fetch after lat cycles (1..5 random when lat is 0)
  initial forever begin
    @(negedge clk);
    if (resp_on) begin
      if (pend) chk("req_stable", {23'b0, imem_req, imem_addr}, {23'b0, 1'b1, pend_addr});
      pend = 1'b0;
      if (imem_valid) imem_valid = 1'b0;
      else if (imem_req) begin
        if (cnt == 0) cnt = lat != 0 ? lat : int'($urandom_range(1, 5));
        cnt--;
        pend = cnt != 0;
        pend_addr = imem_addr;
        if (cnt == 0) begin
          imem_valid = 1'b1;
          imem_data = mem[imem_addr];
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rf_we && mon_on) begin
      we_cnt++;
      if (q.size() == 0) chk("wr_extra", 32'(q.size()), 1);
      else chk("wr", {22'b0, rf_wad, rf_wd}, {22'b0, q.pop_front()});
    end
  end

  initial begin
    int cyc;
    bit ok;
    v[0].prog[0] = ldi(2'd1, 8'h05); v[0].prog[1] = ldi(2'd2, 8'h03);
    v[0].prog[2] = alu(4'h2, 2'd3, 2'd1, 2'd2); v[0].prog[3] = HALT;
    hdr(0, 4, 1, 1'b0, 11, 8'h03, 1'b0, 3);
    v[0].wr[0] = w(2'd1, 8'h05); v[0].wr[1] = w(2'd2, 8'h03); v[0].wr[2] = w(2'd3, 8'h08);
    v[1] = v[0];
    hdr(1, 4, 0, 1'b1, 0, 8'h03, 1'b0, 3);
    v[2].prog[0] = ldi(2'd0, 8'h01); v[2].prog[1] = ldi(2'd1, 8'h02);
    v[2].prog[2] = alu(4'h3, 2'd2, 2'd0, 2'd1); v[2].prog[3] = HALT;
    hdr(2, 4, 1, 1'b0, 11, 8'h03, 1'b0, 3);
    v[2].wr[0] = w(2'd0, 8'h01); v[2].wr[1] = w(2'd1, 8'h02); v[2].wr[2] = w(2'd2, 8'hFF);
    v[3].prog[0] = ldi(2'd0, 8'hF0); v[3].prog[1] = ldi(2'd1, 8'h3C);
    v[3].prog[2] = alu(4'h4, 2'd2, 2'd0, 2'd1); v[3].prog[3] = alu(4'h5, 2'd3, 2'd0, 2'd1);
    v[3].prog[4] = alu(4'h6, 2'd1, 2'd3, 2'd0); v[3].prog[5] = HALT;
    hdr(3, 6, 2, 1'b0, 23, 8'h05, 1'b0, 5);
    v[3].wr[0] = w(2'd0, 8'hF0); v[3].wr[1] = w(2'd1, 8'h3C); v[3].wr[2] = w(2'd2, 8'h30);
    v[3].wr[3] = w(2'd3, 8'hFC); v[3].wr[4] = w(2'd1, 8'hFC);
    v[4].prog[0] = ldi(2'd0, 8'h00); v[4].prog[1] = jz(2'd0, 8'h10);
    hdr(4, 2, 1, 1'b0, 7, 8'h10, 1'b0, 1);
    v[4].wr[0] = w(2'd0, 8'h00);
    v[5].prog[0] = ldi(2'd0, 8'h01); v[5].prog[1] = jz(2'd0, 8'h10); v[5].prog[2] = HALT;
    hdr(5, 3, 1, 1'b0, 7, 8'h02, 1'b0, 1);
    v[5].wr[0] = w(2'd0, 8'h01);
    v[6].prog[0] = ldi(2'd1, 8'hFF); v[6].prog[1] = alu(4'h2, 2'd1, 2'd1, 2'd1);
    v[6].prog[2] = alu(4'h2, 2'd1, 2'd1, 2'd1); v[6].prog[3] = HALT;
    hdr(6, 4, 0, 1'b1, 0, 8'h03, 1'b0, 3);
    v[6].wr[0] = w(2'd1, 8'hFF); v[6].wr[1] = w(2'd1, 8'hFE); v[6].wr[2] = w(2'd1, 8'hFC);
    v[7].prog[0] = 16'h0000; v[7].prog[1] = 16'hB000;
    hdr(7, 2, 3, 1'b0, 8, 8'h01, 1'b1, 0);

    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_wport", {22'b0, rf_wad, rf_wd}, 0);
    chk("rst_rad", {28'b0, rf_arad, rf_brad}, 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_status", {29'b0, busy, halted, illegal}, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      load(i);
      q.delete();
      for (int k = 0; k < v[i].nwr; k++) q.push_back(v[i].wr[k]);
      run(v[i].poke, cyc);
      chk($sformatf("v%0d_halted", i), 32'(halted), 1);
      chk($sformatf("v%0d_busy", i), 32'(busy), 0);
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(v[i].pc));
      chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(v[i].ill));
      chk($sformatf("v%0d_we_cycles", i), 32'(we_cnt), 32'(v[i].nwr));
      chk($sformatf("v%0d_wr_missing", i), 32'(q.size()), 0);
      if (v[i].cyc != 0) chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(v[i].cyc));
    end

    // restart after an illegal halt clears illegal and refetches from 0
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_illegal", 32'(illegal), 0);
    chk("restart_req", 32'(imem_req), 1);
    chk("restart_addr", 32'(imem_addr), 0);
    chk("restart_halted", 32'(halted), 0);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = halted;
    end
    chk("rehalt", 32'(ok), 1);
    chk("reillegal", 32'(illegal), 1);

    // reset while the first write-back is on the bus
    load(0);
    mon_on = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !rf_we; i++) @(negedge clk);
    chk("wb_reached", 32'(rf_we), 1);
    rst = 1'b1;
    #1;
    chk("wbrst_we", 32'(rf_we), 0);
    chk("wbrst_wport", {22'b0, rf_wad, rf_wd}, 0);
    chk("wbrst_status", {29'b0, busy, halted, illegal}, 0);
    chk("wbrst_pc", 32'(pc), 0);
    @(negedge clk);
    rst = 1'b0;
    chk("wbrst_rf1", 32'(rf[1]), 0);
    repeat (3) begin
      @(negedge clk);
      chk("wbrst_idle", {30'b0, busy, rf_we}, 0);
    end
    mon_on = 1'b1;

    // reset during an outstanding fetch, then a stale response
    load(0);
    lat = 5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    resp_on = 1'b0;
    pend = 1'b0;
    cnt = 0;
    @(negedge clk);
    chk("fetch_pending", 32'(imem_req), 1);
    rst = 1'b1;
    #1;
    chk("frst_req", 32'(imem_req), 0);
    chk("frst_busy", 32'(busy), 0);
    chk("frst_pc", 32'(pc), 0);
    @(negedge clk);
    rst = 1'b0;
    imem_valid = 1'b1;
    imem_data = ldi(2'd1, 8'h05);
    repeat (3) begin
      @(negedge clk);
      chk("stale_resp", {28'b0, busy, halted, rf_we, imem_req}, 0);
      chk("stale_pc", 32'(pc), 0);
    end
    imem_valid = 1'b0;
    resp_on = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
